// File: rtl/sfix_32_en28_moving_average_pkg.sv
// Shared definitions for the sfix32_En28 moving-average filter.
//   SFIX_WL / SFIX_FL : sample word and fraction length (N32.Q28)
//   state_e           : flush/clear FSM states
//   sum_width()       : width of the exact running sum for a given window
package sfix_32_en28_moving_average_pkg;

    localparam int SFIX_WL = 32;
    localparam int SFIX_FL = 28;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // N samples of SFIX_WL bits sum to at most SFIX_WL + log2(N) bits.
    function automatic int sum_width(input int log2_len);
        return SFIX_WL + log2_len;
    endfunction

endpackage

// File: rtl/sfix_32_en28_moving_average_if.sv
// Streaming bus of the moving-average filter.
//   flush      : synchronous history-clear request (upstream -> filter)
//   in_valid   : sample valid, in_data sfix32_En28
//   in_ready   : filter can take a sample this cycle
//   out_valid  : one-cycle strobe, out_data is a new average
//   out_primed : a full window has been accepted since the last clear
// master = sample producer / result consumer, slave = the filter.
interface sfix_32_en28_moving_average_if;
    import sfix_32_en28_moving_average_pkg::*;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [SFIX_WL-1:0] in_data;
    logic               out_valid;
    logic [SFIX_WL-1:0] out_data;
    logic               out_primed;

    modport master (
        output flush, in_valid, in_data,
        input  in_ready, out_valid, out_data, out_primed
    );

    modport slave (
        input  flush, in_valid, in_data,
        output in_ready, out_valid, out_data, out_primed
    );

endinterface

// File: rtl/sfix_32_en28_moving_average_ram.sv
// Window history store: 2^AW words, one synchronous write port and one
// asynchronous read port. No reset so it maps onto distributed RAM; the
// parent zeroes it through the write port.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   raddr_i/rdata_o  : combinational read port
module sfix_32_en28_moving_average_ram #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sfix_32_en28_moving_average.sv
// Boxcar moving average over the last 2^LOG2_LEN sfix32_En28 samples.
// Keeps an exact running sum; each accepted sample yields one averaged
// sample one cycle later. A clear FSM zeroes the history after reset and
// on flush.
//   clk, reset_n : clock, asynchronous active-low reset
//   io (slave)   : streaming bus, see sfix_32_en28_moving_average_if
module sfix_32_en28_moving_average
    import sfix_32_en28_moving_average_pkg::*;
#(
    parameter int LOG2_LEN = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    sfix_32_en28_moving_average_if.slave  io
);

    localparam int N  = 1 << LOG2_LEN;
    localparam int SW = sum_width(LOG2_LEN);
    localparam int PW = LOG2_LEN;

    localparam logic [PW:0]   FILL_FULL = (PW+1)'(N);
    localparam logic [PW-1:0] PTR_LAST  = PW'(N - 1);

    state_e              state_q, state_d;
    logic [PW-1:0]       clr_ptr_q, clr_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic signed [SW-1:0] sum_q, sum_d;
    logic [PW:0]         fill_q, fill_d;
    logic                primed_q, primed_d;
    logic                ov_q, ov_d;
    logic [SFIX_WL-1:0]  od_q, od_d;

    logic                accept;
    logic [SFIX_WL-1:0]  oldest;
    logic signed [SW-1:0] in_ext, old_ext, sum_nxt;
    logic                ram_we;
    logic [PW-1:0]       ram_waddr;
    logic [SFIX_WL-1:0]  ram_wdata;

    assign io.in_ready   = (state_q == ST_RUN) && !io.flush;
    assign accept        = io.in_valid && io.in_ready;

    assign io.out_valid  = ov_q;
    assign io.out_data   = od_q;
    assign io.out_primed = primed_q;

    // CLEAR owns the write port; in RUN it only writes on acceptance.
    assign ram_we    = (state_q == ST_CLEAR) || accept;
    assign ram_waddr = (state_q == ST_CLEAR) ? clr_ptr_q : wr_ptr_q;
    assign ram_wdata = (state_q == ST_CLEAR) ? '0 : io.in_data;

    sfix_32_en28_moving_average_ram #(
        .AW (PW),
        .DW (SFIX_WL)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (wr_ptr_q),
        .rdata_o (oldest)
    );

    assign in_ext  = {{LOG2_LEN{io.in_data[SFIX_WL-1]}}, io.in_data};
    assign old_ext = {{LOG2_LEN{oldest[SFIX_WL-1]}}, oldest};
    assign sum_nxt = sum_q + in_ext - old_ext;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        sum_d     = sum_q;
        fill_d    = fill_q;
        primed_d  = primed_q;
        ov_d      = accept;
        od_d      = od_q;

        if (io.flush) begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
            wr_ptr_d  = '0;
            sum_d     = '0;
            fill_d    = '0;
            primed_d  = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                    if (clr_ptr_q == PTR_LAST) state_d = ST_RUN;
                end
                default: begin
                    if (accept) begin
                        sum_d    = sum_nxt;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        fill_d   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
                        if (fill_d == FILL_FULL) primed_d = 1'b1;
                        // Top SFIX_WL bits of the sum == sum >>> LOG2_LEN
                        // (floor); the average of in-range samples always fits.
                        od_d     = sum_nxt[SW-1 -: SFIX_WL];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            wr_ptr_q  <= '0;
            sum_q     <= '0;
            fill_q    <= '0;
            primed_q  <= 1'b0;
            ov_q      <= 1'b0;
            od_q      <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            sum_q     <= sum_d;
            fill_q    <= fill_d;
            primed_q  <= primed_d;
            ov_q      <= ov_d;
            od_q      <= od_d;
        end
    end

endmodule

// File: tb/tb_sfix_32_en28_moving_average.sv
// Directed bench for the moving-average filter with a 4-sample window.
module tb_sfix_32_en28_moving_average;
    import sfix_32_en28_moving_average_pkg::*;

    localparam logic [31:0] ONE = 32'h1000_0000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sfix_32_en28_moving_average_if bus();

    sfix_32_en28_moving_average #(.LOG2_LEN(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        ov;
        logic [31:0] od;
        logic        pr;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic ov,
                       input logic [31:0] od, input logic pr);
        vec_t r;
        r.v = v; r.d = d; r.ov = ov; r.od = od; r.pr = pr;
        tbl.push_back(r);
    endtask

    // Drive inputs, take one rising edge, land 1 time unit after it.
    task automatic cyc(input logic v, input logic [31:0] d, input logic f);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            cyc(tbl[i].v, tbl[i].d, 1'b0);
            chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            chk($sformatf("row%0d out_data", i), bus.out_data, tbl[i].od);
            chk($sformatf("row%0d out_primed", i), 32'(bus.out_primed), 32'(tbl[i].pr));
            chk($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'd1);
        end
    endtask

    // CLEAR lasts 4 edges; in_ready must be low after edges 1-3, high after 4.
    task automatic wait_clear(input string tag);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s clear%0d in_ready", tag, i), 32'(bus.in_ready), (i == 4) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " rst out_valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, " rst out_data"},   bus.out_data,        32'd0);
        chk({tag, " rst out_primed"}, 32'(bus.out_primed), 32'd0);
        chk({tag, " rst in_ready"},   32'(bus.in_ready),   32'd0);
    endtask

    logic [31:0] gap_exp [5];
    logic [31:0] held;

    initial begin
        // constant 1.0 ramp-up
        add(1, ONE, 1, 32'h0400_0000, 0);
        add(1, ONE, 1, 32'h0800_0000, 0);
        add(1, ONE, 1, 32'h0C00_0000, 0);
        add(1, ONE, 1, 32'h1000_0000, 1);
        add(1, ONE, 1, 32'h1000_0000, 1);
        // drain to zero, then a single -1 LSB: floor(-1/4) = -1 for 4 strobes
        add(1, 32'h0, 1, 32'h0C00_0000, 1);
        add(1, 32'h0, 1, 32'h0800_0000, 1);
        add(1, 32'h0, 1, 32'h0400_0000, 1);
        add(1, 32'h0, 1, 32'h0000_0000, 1);
        add(1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1);
        add(1, 32'h0, 1, 32'hFFFF_FFFF, 1);
        add(1, 32'h0, 1, 32'hFFFF_FFFF, 1);
        add(1, 32'h0, 1, 32'hFFFF_FFFF, 1);
        add(1, 32'h0, 1, 32'h0000_0000, 1);
        // positive full scale
        add(1, 32'h7FFF_FFFF, 1, 32'h1FFF_FFFF, 1);
        add(1, 32'h7FFF_FFFF, 1, 32'h3FFF_FFFF, 1);
        add(1, 32'h7FFF_FFFF, 1, 32'h5FFF_FFFF, 1);
        add(1, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 1);
        // negative full scale replacing it
        add(1, 32'h8000_0000, 1, 32'h3FFF_FFFF, 1);
        add(1, 32'h8000_0000, 1, 32'hFFFF_FFFF, 1);
        add(1, 32'h8000_0000, 1, 32'hBFFF_FFFF, 1);
        add(1, 32'h8000_0000, 1, 32'h8000_0000, 1);
        // idle: no strobe, data held
        add(0, 32'h1234_5678, 0, 32'h8000_0000, 1);

        gap_exp[0] = 32'h0400_0000; gap_exp[1] = 32'h0800_0000;
        gap_exp[2] = 32'h0C00_0000; gap_exp[3] = 32'h1000_0000;
        gap_exp[4] = 32'h1000_0000;

        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        reset_n = 1'b0;
        #12;
        chk_reset("por");
        @(posedge clk); #3; reset_n = 1'b1;
        wait_clear("por");
        apply_rows(0, tbl.size() - 1);

        // flush mid-stream together with in_valid
        for (int k = 0; k < 6; k++) begin
            cyc(1, ONE, 0);
            chk($sformatf("pre%0d out_valid", k), 32'(bus.out_valid), 32'd1);
        end
        chk("pre out_data", bus.out_data, ONE);
        chk("pre out_primed", 32'(bus.out_primed), 32'd1);
        bus.in_valid = 1'b1; bus.in_data = ONE; bus.flush = 1'b1;
        #1;
        chk("flush in_ready", 32'(bus.in_ready), 32'd0);
        chk("flush pending out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush out_primed", 32'(bus.out_primed), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("fclr%0d in_ready", i), 32'(bus.in_ready), (i == 4) ? 32'd1 : 32'd0);
            chk($sformatf("fclr%0d out_valid", i), 32'(bus.out_valid), 32'd0);
        end

        // gapped 1-on / 2-off input after the flush
        for (int s = 0; s < 5; s++) begin
            cyc(1, ONE, 0);
            chk($sformatf("gap%0d out_valid", s), 32'(bus.out_valid), 32'd1);
            chk($sformatf("gap%0d out_data", s), bus.out_data, gap_exp[s]);
            chk($sformatf("gap%0d out_primed", s), 32'(bus.out_primed), (s >= 3) ? 32'd1 : 32'd0);
            held = gap_exp[s];
            for (int g = 0; g < 2; g++) begin
                cyc(0, 32'hDEAD_BEEF, 0);
                chk($sformatf("gap%0d.%0d out_valid", s, g), 32'(bus.out_valid), 32'd0);
                chk($sformatf("gap%0d.%0d hold", s, g), bus.out_data, held);
            end
        end

        // async reset mid-RUN with a strobe in flight
        cyc(1, ONE, 0);
        #2; reset_n = 1'b0; #1;
        chk_reset("run");
        bus.in_valid = 1'b0;
        @(posedge clk); #3; reset_n = 1'b1;
        wait_clear("run");
        apply_rows(0, 4);

        // flush during CLEAR restarts the count
        cyc(0, 32'h0, 1);
        cyc(0, 32'h0, 0);
        cyc(0, 32'h0, 0);
        chk("reclr in_ready", 32'(bus.in_ready), 32'd0);
        cyc(0, 32'h0, 1);
        wait_clear("reflush");

        // async reset mid-CLEAR: out_data still holds 1.0 here
        cyc(0, 32'h0, 1);
        cyc(0, 32'h0, 0);
        #2; reset_n = 1'b0; #1;
        chk_reset("clr");
        @(posedge clk); #3; reset_n = 1'b1;
        wait_clear("clr");
        apply_rows(0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
